// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus: one driver enabled at a time,
// burst-limited grants separated by an all-off turnaround gap.
module tristate_bus_arbiter #(
  parameter int N          = 4,
  parameter int DW         = 8,
  parameter int MAX_BURST  = 4,
  parameter int TURNAROUND = 1,
  localparam int OW        = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] din,
  output logic [N-1:0]    gnt,
  output logic [OW-1:0]   owner,
  output logic            busy,
  inout  wire  [DW-1:0]   bus
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TURNAROUND + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic [OW-1:0] r_owner, w_owner_nxt;
  logic [OW-1:0] r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [TW-1:0] r_turn, w_turn_nxt;
  logic          w_any;
  logic [OW-1:0] w_pick;
  logic [N-1:0]  w_en;

  // First requester at or after the pointer, searching cyclically
  always_comb begin
    int idx;
    idx    = 0;
    w_any  = 1'b0;
    w_pick = '0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(r_ptr) + i) % N;
      if (!w_any && req[idx]) begin
        w_any  = 1'b1;
        w_pick = OW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_turn  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_turn  <= w_turn_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_turn_nxt  = r_turn;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = N'(1) << w_pick;
          w_owner_nxt = w_pick;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_GRANT: begin
        if (!req[r_owner] || (r_cnt == CW'(MAX_BURST))) begin
          w_state_nxt = S_TURN;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = (r_owner == OW'(N - 1)) ? '0 : r_owner + OW'(1);
          w_cnt_nxt   = '0;
          w_turn_nxt  = TW'(1);
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_TURN: begin
        // Requests are only looked at on the edge that closes the gap
        if (r_turn == TW'(TURNAROUND)) begin
          w_turn_nxt = '0;
          if (w_any) begin
            w_state_nxt = S_GRANT;
            w_gnt_nxt   = N'(1) << w_pick;
            w_owner_nxt = w_pick;
            w_cnt_nxt   = CW'(1);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_turn_nxt = r_turn + TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt   = r_gnt;
    owner = r_owner;
    busy  = |r_gnt;
    w_en  = r_gnt;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_drv
    assign bus = w_en[gi] ? din[gi*DW +: DW] : {DW{1'bz}};
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed-vector bench: stimulus queues the expected bus state per cycle,
// a negedge monitor pops and compares, and also watches the one-hot invariant.
module tb_tristate_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   din;
  logic [N-1:0]      gnt;
  logic [1:0]        owner;
  logic              busy;
  wire  [DW-1:0]     bus;

  typedef struct {
    logic [3:0] g;
    logic [1:0] o;
    logic [7:0] b;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  tristate_bus_arbiter #(.N(4), .DW(8), .MAX_BURST(4), .TURNAROUND(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // Monitor: invariant checks plus scoreboard pop every cycle out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n_cmp++;
        if ($countones(gnt) > 1) begin
          n_bad++;
          $display("FAIL onehot: gnt=%b, required at most one bit set", gnt);
        end
        if (busy) begin
          n_cmp++;
          if ($isunknown(bus)) begin
            n_bad++;
            $display("FAIL bus_known: bus=%h, required no X/Z while granted", bus);
          end
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          n_cmp++;
          if (gnt !== e.g || owner !== e.o || busy !== (|e.g) ||
              ((|e.g) && bus !== e.b)) begin
            n_bad++;
            $display("FAIL %s: gnt=%b owner=%0d busy=%b bus=%h, required gnt=%b owner=%0d busy=%b bus=%h",
                     e.nm, gnt, owner, busy, bus, e.g, e.o, |e.g, e.b);
          end
        end
      end
    end
  end

  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] o,
                      input logic [7:0] b, input string nm);
    @(negedge clk);
    #1;
    req = r;
    q.push_back('{g: g, o: o, b: b, nm: nm});
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h, required=%h", nm, got, want);
    end
  endtask

  localparam logic [7:0] D0 = 8'h11, D1 = 8'h3C, D2 = 8'hA5, D3 = 8'hC3;

  initial begin
    logic [7:0] dv [4];
    logic [3:0] gk;
    int         w;
    dv[0] = D0; dv[1] = D1; dv[2] = D2; dv[3] = D3;
    din   = {D3, D2, D1, D0};

    // Reset with everyone requesting
    rst_n = 1'b0;
    req   = 4'b1111;
    #23;
    chk("rst_gnt",   8'(gnt),   8'h00);
    chk("rst_busy",  8'(busy),  8'h00);
    chk("rst_owner", 8'(owner), 8'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b0000;
    step(4'b0000, 4'b0000, 2'd0, 8'h00, "idle_after_rst0");
    step(4'b0000, 4'b0000, 2'd0, 8'h00, "idle_after_rst1");

    // All requesting: full rotation from pointer 0, wrapping back to 0
    for (int k = 0; k < 4; k++) begin
      gk = 4'b0001 << k;
      for (int c = 0; c < 4; c++) step(4'b1111, gk, 2'(k), dv[k], "all_burst");
      step(4'b1111, 4'b0000, 2'(k), 8'h00, "all_turn");
    end
    step(4'b1111, 4'b0001, 2'd0, D0, "all_wrap");
    step(4'b0000, 4'b0000, 2'd0, 8'h00, "all_release");
    step(4'b0000, 4'b0000, 2'd0, 8'h00, "all_idle");

    // Single requester 2, three cycles (pointer now 1)
    for (int c = 0; c < 3; c++) step(4'b0100, 4'b0100, 2'd2, D2, "single");
    step(4'b0000, 4'b0000, 2'd2, 8'h00, "single_release");
    step(4'b0000, 4'b0000, 2'd2, 8'h00, "single_idle");

    // Burst limit with requester 1 holding request (pointer now 3)
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) step(4'b0010, 4'b0010, 2'd1, D1, "burst_hold");
      step(4'b0010, 4'b0000, 2'd1, 8'h00, "burst_turn");
    end
    step(4'b0010, 4'b0010, 2'd1, D1, "burst_regain0");
    step(4'b0010, 4'b0010, 2'd1, D1, "burst_regain1");
    step(4'b0000, 4'b0000, 2'd1, 8'h00, "burst_release");
    step(4'b0000, 4'b0000, 2'd1, 8'h00, "burst_idle");

    // Rotation priority: 2 releases, then 1001 -> 3 first, then 0
    step(4'b0100, 4'b0100, 2'd2, D2, "rot_own2_0");
    step(4'b0100, 4'b0100, 2'd2, D2, "rot_own2_1");
    step(4'b1001, 4'b0000, 2'd2, 8'h00, "rot_turn");
    for (int c = 0; c < 4; c++) step(4'b1001, 4'b1000, 2'd3, D3, "rot_own3");
    step(4'b1001, 4'b0000, 2'd3, 8'h00, "rot_turn3");
    step(4'b1001, 4'b0001, 2'd0, D0, "rot_own0");
    step(4'b0000, 4'b0000, 2'd0, 8'h00, "rot_release");
    step(4'b0000, 4'b0000, 2'd0, 8'h00, "rot_idle");

    // Request drops on the same edge the burst limit is reached
    for (int c = 0; c < 4; c++) step(4'b0010, 4'b0010, 2'd1, D1, "same_edge_burst");
    step(4'b0000, 4'b0000, 2'd1, 8'h00, "same_edge_release");
    step(4'b0000, 4'b0000, 2'd1, 8'h00, "same_edge_idle");

    // Asynchronous reset in the middle of a grant to requester 1
    step(4'b0010, 4'b0010, 2'd1, D1, "pre_rst0");
    step(4'b0010, 4'b0010, 2'd1, D1, "pre_rst1");
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    req   = 4'b1010;
    #1;
    chk("async_rst_gnt",   8'(gnt),   8'h00);
    chk("async_rst_busy",  8'(busy),  8'h00);
    chk("async_rst_owner", 8'(owner), 8'h00);
    @(negedge clk);
    chk("rst_hold_gnt", 8'(gnt), 8'h00);
    #1;
    rst_n = 1'b1;
    q.push_back('{g: 4'b0010, o: 2'd1, b: D1, nm: "post_rst_first"});
    step(4'b1010, 4'b0010, 2'd1, D1, "post_rst_hold");
    step(4'b0000, 4'b0000, 2'd1, 8'h00, "post_rst_release");
    step(4'b0000, 4'b0000, 2'd1, 8'h00, "post_rst_idle");

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(negedge clk);
      #2;
      w++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
